spi_shift_master: RTL and testbench

Parametrised successor to the single-lane SPI bit shifter. It serialises a WIDTH-bit word onto the serial data output and captures the same number of bits from sdo. It generates o_clk from clk through a programmable divider and drives one of NCS active-low chip selects. Supports all four CPOL/CPHA modes, selected per transaction, and sits between the register/command logic and the SPI pins.

---
 rtl/spi_shift_pkg.sv | 21 ++
 rtl/spi_sclk_gen.sv | 38 +++
 rtl/spi_shift_master.sv | 151 +++++++++++++++
 tb/tb_spi_shift_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_shift_pkg.sv
// Shared types for the SPI shift master: FSM states, per-transaction mode,
// and the chip-select index width helper.
package spi_shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    function automatic int cs_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period divider producing single-cycle edge
// strobes and the o_clk level relative to the latched polarity.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic mute,
    input  logic cpol,
    output logic lead_stb,
    output logic trail_stb,
    output logic hp_end,
    output logic o_clk
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          inv;

    assign hp_end    = run && (div_cnt == CW'(CLK_DIV - 1));
    assign lead_stb  = hp_end && !mute && !inv;
    assign trail_stb = hp_end && !mute && inv;
    // Strobes fire in the cycle before the clk edge that moves o_clk.
    assign o_clk     = cpol ^ inv;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= '0;
            inv     <= 1'b0;
        end else begin
            div_cnt <= hp_end ? '0 : div_cnt + 1'b1;
            if (hp_end && !mute)
                inv <= ~inv;
        end
    end

endmodule

// File: rtl/spi_shift_master.sv
// Parametrised SPI shift master with CPOL/CPHA per transaction.
// Optional macro SPI_SHIFT_LOOPBACK_EN adds lb_en (capture from miso).
module spi_shift_master
    import spi_shift_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CLK_DIV   = 4,
    parameter int NCS       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [cs_w(NCS)-1:0] cs_sel,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic [WIDTH-1:0]     tx_data,
    input  logic                 sdo,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic                 lb_en,
`endif
    output logic                 miso,
    output logic                 o_clk,
    output logic [NCS-1:0]       o_cs,
    output logic                 o_cs_en,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     rx_data
);
    localparam int CSW = cs_w(NCS);
    localparam int HPW = $clog2(2 * WIDTH);

    state_t           state, state_nxt;
    mode_t            mode_q;
    logic [CSW-1:0]   cs_q;
    logic [HPW-1:0]   hp_cnt;
    logic [WIDTH-1:0] tx_sh, rx_sh;
    logic             lead_stb, trail_stb, hp_end;
    logic             last_hp, mute, accept, sample_stb, update_stb, din;

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] push_bit(input logic [WIDTH-1:0] v, input logic b);
        return (MSB_FIRST != 0) ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
    endfunction

    assign busy       = (state != IDLE);
    assign accept     = (state == IDLE) && start;
    assign last_hp    = (state == SHIFT) && (hp_cnt == HPW'(2 * WIDTH - 1));
    // No edge at the SHIFT->TRAIL boundary or inside TRAIL: o_clk rests at cpol.
    assign mute       = last_hp || (state == TRAIL);
    assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;
    assign update_stb = mode_q.cpha ? lead_stb : trail_stb;

`ifdef SPI_SHIFT_LOOPBACK_EN
    logic lb_q;
    always_ff @(posedge clk) begin
        if (rst)
            lb_q <= 1'b0;
        else if (accept)
            lb_q <= lb_en;
    end
    assign din = lb_q ? miso : sdo;
`else
    assign din = sdo;
`endif

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .run      (busy),
        .mute     (mute),
        .cpol     (mode_q.cpol),
        .lead_stb (lead_stb),
        .trail_stb(trail_stb),
        .hp_end   (hp_end),
        .o_clk    (o_clk)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (hp_end) state_nxt = SHIFT;
            SHIFT:   if (hp_end && last_hp) state_nxt = TRAIL;
            TRAIL:   if (hp_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            cs_q    <= '0;
            hp_cnt  <= '0;
            miso    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= (state == TRAIL) && hp_end;
            if ((state == TRAIL) && hp_end)
                rx_data <= rx_sh;
            if (state == SHIFT && hp_end)
                hp_cnt <= hp_cnt + 1'b1;
            if (accept) begin
                mode_q <= '{cpol: cpol, cpha: cpha};
                cs_q   <= cs_sel;
                hp_cnt <= '0;
                if (!cpha)
                    miso <= first_bit(tx_data);
            end else if (update_stb) begin
                miso <= first_bit(tx_sh);
            end
        end
    end

    // Shift registers need no reset: every transaction reloads or refills them.
    always_ff @(posedge clk) begin
        if (accept)
            tx_sh <= cpha ? tx_data : drop_first(tx_data);
        else if (update_stb)
            tx_sh <= drop_first(tx_sh);
        if (sample_stb)
            rx_sh <= push_bit(rx_sh, din);
    end

    always_comb begin
        o_cs = '1;
        for (int i = 0; i < NCS; i++)
            if (busy && (int'(cs_q) == i))
                o_cs[i] = 1'b0;
    end

    assign o_cs_en = busy && (int'(cs_q) < NCS);

endmodule

// File: tb/tb_spi_shift_master.sv
// Directed bench for spi_shift_master with a behavioural SPI slave on u0.
module tb_spi_shift_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: WIDTH=8 CLK_DIV=2 NCS=2 MSB_FIRST=1
    logic       start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0, sdo0 = 1'b0;
    logic [0:0] cs_sel0 = '0;
    logic [7:0] tx0 = '0;
    logic       miso0, o_clk0, o_cs_en0, busy0, done0;
    logic [1:0] o_cs0;
    logic [7:0] rx_data0;

    // u1: WIDTH=8 CLK_DIV=1 NCS=3 MSB_FIRST=0
    logic       start1 = 1'b0, cpol1 = 1'b0, cpha1 = 1'b0, sdo1 = 1'b0;
    logic [1:0] cs_sel1 = '0;
    logic [7:0] tx1 = '0;
    logic       miso1, o_clk1, o_cs_en1, busy1, done1;
    logic [2:0] o_cs1;
    logic [7:0] rx_data1;

    spi_shift_master #(.WIDTH(8), .CLK_DIV(2), .NCS(2), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .cs_sel(cs_sel0), .cpol(cpol0),
        .cpha(cpha0), .tx_data(tx0), .sdo(sdo0),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .lb_en(1'b0),
`endif
        .miso(miso0), .o_clk(o_clk0), .o_cs(o_cs0), .o_cs_en(o_cs_en0),
        .busy(busy0), .done(done0), .rx_data(rx_data0)
    );

    spi_shift_master #(.WIDTH(8), .CLK_DIV(1), .NCS(3), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .cs_sel(cs_sel1), .cpol(cpol1),
        .cpha(cpha1), .tx_data(tx1), .sdo(sdo1),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .lb_en(1'b0),
`endif
        .miso(miso1), .o_clk(o_clk1), .o_cs(o_cs1), .o_cs_en(o_cs_en1),
        .busy(busy1), .done(done1), .rx_data(rx_data1)
    );

`ifdef SPI_SHIFT_LOOPBACK_EN
    logic       start2 = 1'b0, lb2 = 1'b0;
    logic [7:0] tx2 = '0;
    logic       miso2, o_clk2, o_cs_en2, busy2, done2;
    logic [1:0] o_cs2;
    logic [7:0] rx_data2;

    spi_shift_master #(.WIDTH(8), .CLK_DIV(2), .NCS(2), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .cs_sel(1'b0), .cpol(1'b0),
        .cpha(1'b0), .tx_data(tx2), .sdo(1'b0), .lb_en(lb2),
        .miso(miso2), .o_clk(o_clk2), .o_cs(o_cs2), .o_cs_en(o_cs_en2),
        .busy(busy2), .done(done2), .rx_data(rx_data2)
    );
`endif

    // Behavioural slave on u0: sends sl_word MSB first, records what it receives.
    logic [7:0] sl_word = 8'h3C;
    logic [7:0] sl_tx = '0, sl_rx = '0;
    int         sl_samples = 0, sl_rises = 0;
    logic       sl_busy_q = 1'b0, sl_clk_q = 1'b0;
    time        sl_t0 = 0;

    always @(busy0 or o_clk0) begin
        if (busy0 && !sl_busy_q) begin
            sl_tx = sl_word; sl_rx = '0; sl_samples = 0; sl_rises = 0; sl_t0 = $time;
            if (!cpha0) begin
                sdo0 = sl_tx[7]; sl_tx = sl_tx << 1;
            end
        end else if (busy0 && (o_clk0 !== sl_clk_q) && ($time != sl_t0)) begin
            if ((o_clk0 != cpol0) == cpha0) begin
                sdo0 = sl_tx[7]; sl_tx = sl_tx << 1;
            end else begin
                sl_rx = {sl_rx[6:0], miso0}; sl_samples++;
                if (o_clk0) sl_rises++;
            end
        end
        sl_busy_q = busy0;
        sl_clk_q  = o_clk0;
    end

    int done_cnt0 = 0;
    always @(negedge clk) if (done0 === 1'b1) done_cnt0++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go0(input logic sel, input logic p, input logic h, input logic [7:0] tx);
        cs_sel0 = sel; cpol0 = p; cpha0 = h; tx0 = tx; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int lat0, input logic [1:0] exp_cs, output int lat, output int bad);
        lat = lat0; bad = 0;
        while (done0 !== 1'b1 && lat < 200) begin
            if (busy0 && o_cs0 !== exp_cs) bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bad, n0;
        repeat (3) @(negedge clk);
        chk("rst_o_clk", o_clk0, 0);
        chk("rst_o_cs", o_cs0, 2'b11);
        chk("rst_o_cs_en", o_cs_en0, 0);
        chk("rst_miso", miso0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rx", rx_data0, 0);
        chk("rst_u1_o_cs", o_cs1, 3'b111);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0
        go0(1'b0, 1'b0, 1'b0, 8'hA5);
        chk("m0_cs_lead", o_cs0, 2'b10);
        chk("m0_cs_en", o_cs_en0, 1);
        chk("m0_first_miso", miso0, 1);
        chk("m0_clk_lead", o_clk0, 0);
        wait_done0(1, 2'b10, lat, bad);
        chk("m0_latency", lat, 37);
        chk("m0_cs_hold", bad, 0);
        chk("m0_rx", rx_data0, 8'h3C);
        chk("m0_slave_rx", sl_rx, 8'hA5);
        chk("m0_samples", sl_samples, 8);
        chk("m0_busy_at_done", busy0, 0);
        chk("m0_cs_release", o_cs0, 2'b11);
        @(negedge clk);
        chk("m0_done_pulse", done0, 0);

        // Mode 3
        go0(1'b0, 1'b1, 1'b1, 8'hA5);
        chk("m3_clk_idle_pre", o_clk0, 1);
        wait_done0(1, 2'b10, lat, bad);
        chk("m3_latency", lat, 37);
        chk("m3_rx", rx_data0, 8'h3C);
        chk("m3_slave_rx", sl_rx, 8'hA5);
        chk("m3_rising_samples", sl_rises, 8);
        chk("m3_clk_idle_post", o_clk0, 1);
        @(negedge clk);

        // start while busy is ignored; start in done cycle is accepted
        n0 = done_cnt0;
        go0(1'b0, 1'b0, 1'b0, 8'h96);
        chk("m0_clk_repol", o_clk0, 0);
        repeat (9) @(negedge clk);
        tx0 = 8'hFF; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(11, 2'b10, lat, bad);
        chk("busy_start_latency", lat, 37);
        chk("busy_start_slave_rx", sl_rx, 8'h96);
        go0(1'b0, 1'b0, 1'b0, 8'h5A);
        chk("b2b_done_one_cycle", done0, 0);
        chk("b2b_busy", busy0, 1);
        wait_done0(1, 2'b10, lat, bad);
        chk("b2b_latency", lat, 37);
        chk("b2b_slave_rx", sl_rx, 8'h5A);
        @(posedge clk);
        chk("done_count", done_cnt0 - n0, 2);
        @(negedge clk);

        // Reset during SHIFT bit 3
        n0 = done_cnt0;
        go0(1'b0, 1'b0, 1'b0, 8'hA5);
        repeat (14) @(negedge clk);
        chk("mid_busy", busy0, 1);
        chk("mid_clk_high", o_clk0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_o_cs", o_cs0, 2'b11);
        chk("abort_cs_en", o_cs_en0, 0);
        chk("abort_o_clk", o_clk0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_rx", rx_data0, 0);
        chk("abort_miso", miso0, 0);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        @(posedge clk);
        chk("abort_no_done", done_cnt0 - n0, 0);
        @(negedge clk);

        // cs_sel = 1
        go0(1'b1, 1'b0, 1'b0, 8'hC3);
        chk("cs1_o_cs", o_cs0, 2'b01);
        wait_done0(1, 2'b01, lat, bad);
        chk("cs1_latency", lat, 37);
        chk("cs1_hold", bad, 0);
        chk("cs1_rx", rx_data0, 8'h3C);
        chk("cs1_slave_rx", sl_rx, 8'hC3);
        @(negedge clk);

        // u1: out-of-range select, LSB first, CLK_DIV=1
        cs_sel1 = 2'd3; tx1 = 8'h01; sdo1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("oor_first_miso", miso1, 1);
        chk("oor_o_cs", o_cs1, 3'b111);
        chk("oor_cs_en", o_cs_en1, 0);
        chk("oor_busy", busy1, 1);
        @(negedge clk);
        chk("div1_clk_a", o_clk1, 1);
        @(negedge clk);
        chk("div1_clk_b", o_clk1, 0);
        @(negedge clk);
        chk("div1_clk_c", o_clk1, 1);
        lat = 4;
        while (done1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("oor_latency", lat, 19);
        chk("oor_rx", rx_data1, 8'hFF);
        @(negedge clk);

        cs_sel1 = 2'd2; tx1 = 8'h80; sdo1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("cs2_o_cs", o_cs1, 3'b011);
        chk("cs2_cs_en", o_cs_en1, 1);
        chk("cs2_first_miso", miso1, 0);
        chk("rx_hold_after_start", rx_data1, 8'hFF);
        lat = 1;
        while (done1 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("cs2_latency", lat, 19);
        chk("cs2_rx", rx_data1, 8'h00);
        @(negedge clk);

`ifdef SPI_SHIFT_LOOPBACK_EN
        lb2 = 1'b1; tx2 = 8'h5A; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (done2 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("lb_on_latency", lat, 37);
        chk("lb_on_rx", rx_data2, 8'h5A);
        @(negedge clk);
        lb2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (done2 !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("lb_off_rx", rx_data2, 8'h00);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
